uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Oversampling UART receiver: the consumer of the uart_baudgen OverSample x baud clock.
//  Recovers 8N1-style frames from the async serial line, samples each bit at mid-bit and
//  presents bytes on a valid/ready interface, flagging framing errors and overruns.
//  Sits between the pad-side rx line and the system-side byte consumer.
// PARAMETERS
//  DataBits    8   data bits per frame, LSB first (5..9)
//  OverSample  16  baud-clock periods per bit; must match uart_baudgen; even, >= 4
//  SyncStages  2   flops in the i_rx metastability synchronizer (>= 2)
// PORTS
//  i_clk        in   1         system clock
//  i_rst_n      in   1         asynchronous active-low reset
//  i_baud_clk   in   1         square wave from uart_baudgen (baud*OverSample), i_clk domain
//  i_rx         in   1         serial line, asynchronous, idle high
//  o_data       out  DataBits  received byte, stable while o_valid=1
//  o_valid      out  1         byte available
//  i_ready      in   1         consumer accepts byte when o_valid & i_ready
//  o_frame_err  out  1         1-cycle pulse: stop bit sampled low
//  o_overrun    out  1         1-cycle pulse: byte completed while holding reg full
// BEHAVIOUR
//  - Reset (async): state IDLE, counters 0, synchronizer flops 1, o_data 0, o_valid 0,
//    o_frame_err 0, o_overrun 0. Reset mid-frame abandons the frame; no output pulse.
//  - tick = rising edge of i_baud_clk: one flop holds previous value, tick = cur & ~prev.
//    All FSM/counter updates occur only on i_clk edges where tick=1.
//  - rx_s = i_rx after SyncStages flops.
//  - FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
//    IDLE: tick & rx_s==0 -> START, os_cnt=0.
//    START: os_cnt counts ticks; at os_cnt==OverSample/2-1 sample rx_s:
//      0 -> DATA, os_cnt=0, bit_cnt=0; 1 -> IDLE (glitch rejected, no flags).
//    DATA: at os_cnt==OverSample-1 shift rx_s into MSB of shift reg (LSB-first line order),
//      os_cnt=0, bit_cnt++; after bit DataBits-1 -> STOP.
//    STOP: at os_cnt==OverSample-1 sample rx_s: 1 -> deliver, IDLE;
//      0 -> o_frame_err pulse, byte discarded, WAIT_IDLE.
//    WAIT_IDLE: stay until rx_s==1 on a tick (break/line-low), then IDLE.
//  - os_cnt width $clog2(OverSample); bit_cnt width $clog2(DataBits+1); no wrap beyond limits.
//  - Deliver: o_data/o_valid registered on the clock of the stop sample; visible next cycle.
//  - Handshake: o_valid held, o_data frozen until o_valid & i_ready; o_valid falls the cycle
//    after acceptance. i_ready with o_valid=0 is ignored.
//  - Simultaneous deliver and acceptance: new byte loaded, o_valid stays 1, no overrun.
//  - Deliver while o_valid=1 and not accepted: o_overrun pulses 1 cycle, new byte dropped,
//    held byte and o_valid unchanged.
//  - Frame error and overrun are mutually exclusive per frame (errored frame never delivers).
// STRUCTURE
//  - uart_pkg: typedef enum logic [2:0] rx_state_e {IDLE,START,DATA,STOP,WAIT_IDLE};
//    default DataBits/OverSample localparams shared with uart_baudgen and uart_tx.
//  - Sub-module uart_sync (SyncStages-deep, reset-to-1 synchronizer) for i_rx.
//  - Remainder in one module: tick detect, FSM, shift reg, holding reg.
// TESTING  (uart_baudgen 50 MHz/9600/16 drives i_baud_clk; bit time = 16 ticks)
//  1 Send 0xA5 (start,1,0,1,0,0,1,0,1,stop), i_ready=1 -> o_data=0xA5, o_valid 1 cycle, no flags.
//  2 Pulse i_rx low for 4 ticks only -> FSM back to IDLE, no o_valid, no o_frame_err.
//  3 Send 0x3C with stop bit 0, then hold line low 3 bits -> one o_frame_err pulse, no o_valid,
//    FSM in WAIT_IDLE until line high; following 0x55 received correctly.
//  4 i_ready=0, send 0x11 then 0x22 -> o_data=0x11 held, o_overrun pulses once at 0x22 stop;
//    raise i_ready -> 0x11 accepted, o_valid falls.
//  5 Back-to-back 0x00,0xFF,0x81 no idle gap, i_ready=1 -> three bytes in order, no flags.
//  6 Assert i_rst_n=0 mid-DATA of 0x5A -> all outputs 0 immediately; after release, next 0xC3
//    received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/oversampling parameters used by
// uart_baudgen, uart_tx and uart_rx, plus the receiver state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_OVER_SAMPLE = 16;
    localparam int UART_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous, idle-high serial line.
// Flops reset to 1 so that a reset never manufactures a false start edge.
module uart_sync #(
    parameter int Stages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [Stages-1:0] sync_ff;

    // Shift the raw line through the chain; the last flop is the clean copy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_ff <= '1;
        end else begin
            sync_ff <= {sync_ff[Stages-2:0], i_d};
        end
    end

    assign o_q = sync_ff[Stages-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver. Detects the start edge, confirms it at
// mid-start-bit, samples each data bit and the stop bit at mid-bit, and
// hands completed bytes to a single-entry holding register.
//
// Output handshake: o_valid/o_data form a valid/ready source. Once o_valid
// rises it stays high and o_data stays frozen until a cycle where
// o_valid & i_ready are both 1; that cycle is the transfer, and o_valid drops
// on the following cycle unless a new byte is loaded on the same edge.
// i_ready while o_valid=0 has no effect.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DataBits   = UART_DATA_BITS,
    parameter int OverSample = UART_OVER_SAMPLE,
    parameter int SyncStages = UART_SYNC_STAGES
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_baud_clk,
    input  logic                i_rx,
    output logic [DataBits-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_frame_err,
    output logic                o_overrun,
    output logic [2:0]          o_state
);

    localparam int OsW = $clog2(OverSample);
    localparam int BcW = $clog2(DataBits + 1);

    localparam logic [OsW-1:0] OS_MID   = OsW'(OverSample / 2 - 1);
    localparam logic [OsW-1:0] OS_LAST  = OsW'(OverSample - 1);
    localparam logic [BcW-1:0] BIT_LAST = BcW'(DataBits - 1);

    logic                baud_prev;
    logic                tick;
    logic                rx_s;
    rx_state_e           state;
    logic [OsW-1:0]      os_cnt;
    logic [BcW-1:0]      bit_cnt;
    logic [DataBits-1:0] shift_reg;
    logic                stop_sample;
    logic                deliver;
    logic                frame_bad;

    uart_sync #(
        .Stages (SyncStages)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    // Remember the previous baud clock level to find its rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_prev <= 1'b0;
        end else begin
            baud_prev <= i_baud_clk;
        end
    end

    assign tick = i_baud_clk & ~baud_prev;

    // Stop-bit sampling point: the only place a frame outcome is decided.
    assign stop_sample = tick && (state == STOP) && (os_cnt == OS_LAST);
    assign deliver     = stop_sample &  rx_s;
    assign frame_bad   = stop_sample & ~rx_s;

    // Frame FSM with oversample and bit counters; advances only on ticks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        os_cnt <= '0;
                    end
                end
                START: begin
                    if (os_cnt == OS_MID) begin
                        // Mid-start-bit: a high line here was only a glitch.
                        os_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        os_cnt <= os_cnt + OsW'(1);
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        // Line is LSB first, so new bits enter at the top.
                        os_cnt    <= '0;
                        shift_reg <= {rx_s, shift_reg[DataBits-1:1]};
                        bit_cnt   <= bit_cnt + BcW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        os_cnt <= os_cnt + OsW'(1);
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt <= '0;
                        state  <= rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        os_cnt <= os_cnt + OsW'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Line held low (break): wait for it to return high.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Holding register, handshake and one-cycle error pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= frame_bad;
            o_overrun   <= 1'b0;
            if (deliver) begin
                if (!o_valid || i_ready) begin
                    // Empty, or the held byte leaves on this same edge.
                    o_data  <= shift_reg;
                    o_valid <= 1'b1;
                end else begin
                    // Held byte wins; the new one is dropped.
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios followed by
// randomized frames, glitches and broken stop bits, all checked against a
// frame-level expectation model (expected byte queue and event counts).
module tb_uart_rx;

    import uart_pkg::*;

    localparam int BIT_TICKS = 16;

    logic       clk;
    logic       rst_n;
    logic       baud_clk;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int fe_exp       = 0;
    int ov_exp       = 0;
    int fe_seen      = 0;
    int ov_seen      = 0;
    int valid_cycles = 0;
    bit rand_ready   = 0;

    uart_rx dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_baud_clk  (baud_clk),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_state     (state)
    );

    // ---------------- clock / reset / baud ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud clock: 2 clk high, 2 clk low -> one tick every 4 clk cycles.
    initial begin
        baud_clk = 1'b0;
        forever begin
            repeat (2) @(negedge clk);
            baud_clk = ~baud_clk;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        repeat (n) @(posedge baud_clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_ticks(BIT_TICKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        wait_ticks(n);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_frame_err_count"}, fe_seen, fe_exp);
        check({tag, "_overrun_count"}, ov_seen, ov_exp);
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin
        bit         prev_held;
        logic [7:0] prev_data;
        prev_held = 0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (prev_held) begin
                    check("hold_valid", valid, 1);
                    check("hold_data", data, prev_data);
                end
                if (valid) valid_cycles++;
                if (frame_err) fe_seen++;
                if (overrun) ov_seen++;
                if (frame_err || overrun) check("err_exclusive", frame_err & overrun, 0);
                if (valid && ready) begin
                    if (exp_q.size() == 0) check("spurious_valid", valid, 0);
                    else check("rx_data", data, exp_q.pop_front());
                end
                prev_held = valid && !ready;
                prev_data = data;
            end else begin
                prev_held = 0;
            end
        end
    end

    // Random ready source used during the randomized phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) ready = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        int kind;
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_valid", valid, 0);
        check("reset_data", data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        check("reset_state", state, 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);

        // 1: single byte, ready high
        valid_cycles = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(24);
        check("t1_valid_cycles", valid_cycles, 1);
        check_counts("t1");

        // 2: short low glitch is rejected
        valid_cycles = 0;
        rx = 1'b0;
        wait_ticks(4);
        idle(30);
        check("t2_state", state, 32'(IDLE));
        check("t2_valid_cycles", valid_cycles, 0);
        check_counts("t2");

        // 3: bad stop bit, line held low, then recovery
        valid_cycles = 0;
        fe_exp++;
        send_frame(8'h3C, 1'b0);
        wait_ticks(3 * BIT_TICKS);
        check("t3_state_wait", state, 32'(WAIT_IDLE));
        check("t3_valid_cycles", valid_cycles, 0);
        check_counts("t3a");
        idle(4);
        check("t3_state_idle", state, 32'(IDLE));
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(24);
        check_counts("t3b");

        // 4: overrun while the consumer stalls
        @(negedge clk);
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(4);
        ov_exp++;
        send_frame(8'h22, 1'b1);
        idle(20);
        check("t4_valid_held", valid, 1);
        check("t4_data_held", data, 8'h11);
        check("t4_overrun_count", ov_seen, ov_exp);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        #2;
        check("t4_valid_fall", valid, 0);
        check_counts("t4");

        // 5: back-to-back frames, no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(24);
        check_counts("t5");

        // 6: reset in the middle of a frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", data, 0);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_frame_err", frame_err, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_state", state, 32'(IDLE));
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle(24);
        check_counts("t6");

        // Randomized: good frames, glitches and broken stop bits
        rand_ready = 1;
        for (int n = 0; n < 20; n++) begin
            kind = $urandom_range(0, 5);
            d = 8'($urandom_range(0, 255));
            if (kind == 0) begin
                rx = 1'b0;
                wait_ticks($urandom_range(1, 5));
                idle($urandom_range(12, 20));
            end else if (kind == 1) begin
                fe_exp++;
                send_frame(d, 1'b0);
                wait_ticks($urandom_range(0, 16));
                idle($urandom_range(4, 12));
            end else begin
                exp_q.push_back(d);
                send_frame(d, 1'b1);
                idle($urandom_range(0, 10));
            end
        end
        idle(24);
        rand_ready = 0;
        @(negedge clk);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        check_counts("rand");
        check("rand_state", state, 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
